// File: rtl/accel_sample_sequencer.sv
// Accelerometer sample sequencer: power-up wait, three config writes, then 6-byte reads per tick.
// Define ACCEL_AVG_EN to publish the arithmetic mean of every 4 consecutive bursts instead of raw samples.
module accel_sample_sequencer #(
   parameter int unsigned SYS_CLK_SPEED   = 32'd50000000,
   parameter int unsigned SAMPLE_RATE_HZ  = 32'd100,
   parameter logic [6:0]  DEV_ADDRESS     = 7'h1D,
   parameter int unsigned POWERUP_CYCLES  = 32'd100000,
   parameter int unsigned TIMEOUT_CYCLES  = 32'd2000000,
   parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   output logic [6:0]  i2c_dev_addr,
   output logic [7:0]  i2c_reg_addr,
   output logic        i2c_r_w,
   output logic [7:0]  i2c_write_data,
   input  logic [7:0]  i2c_read_data,
   output logic        i2c_start,
   input  logic        i2c_finished,
   input  logic        i2c_ready,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        accel_valid,
   output logic        init_done,
   output logic        err,
   output logic        overrun
);
   localparam int unsigned TICK_CYCLES = SYS_CLK_SPEED / SAMPLE_RATE_HZ;

   typedef enum logic [2:0] {
      PWRUP, CFG_ISSUE, CFG_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH, ERROR
   } state_t;

   state_t      state_q;
   logic [31:0] pwr_cnt_q;
   logic [31:0] wd_cnt_q;
   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]  cfg_idx_q;
   logic [2:0]  byte_idx_q;
   logic        accepted_q;
   logic        pending_q, pending_d;
   logic        overrun_q, overrun_d;
   logic [39:0] buf_q;
   logic [6:0]  dev_addr_q;
   logic [7:0]  reg_addr_q, wdata_q;
   logic        r_w_q, start_q, valid_q, init_done_q, err_q;
   logic [15:0] ax_q, ay_q, az_q;
   logic        take_s, tick_s, xfer_done_s, wd_expire_s;
   logic [15:0] raw_x_s, raw_y_s, raw_z_s;
`ifdef ACCEL_AVG_EN
   logic [17:0] acc_x_q, acc_y_q, acc_z_q;
   logic [17:0] sum_x_s, sum_y_s, sum_z_s;
   logic [1:0]  burst_cnt_q;

   function automatic logic [17:0] sext18(input logic [15:0] v);
      sext18 = {{2{v[15]}}, v};
   endfunction
`endif

   function automatic logic [7:0] cfg_reg(input logic [1:0] idx);
      case (idx)
         2'd0:    cfg_reg = 8'h31;
         2'd1:    cfg_reg = 8'h2C;
         2'd2:    cfg_reg = 8'h2D;
         default: cfg_reg = 8'h31;
      endcase
   endfunction

   function automatic logic [7:0] cfg_data(input logic [1:0] idx);
      case (idx)
         2'd0:    cfg_data = DATA_FORMAT_VAL;
         2'd1:    cfg_data = 8'h0A;
         2'd2:    cfg_data = 8'h08;
         default: cfg_data = DATA_FORMAT_VAL;
      endcase
   endfunction

   // The last byte of a burst is used straight from the bus so publish needs no extra cycle.
   always_comb begin
      take_s      = (state_q == IDLE) && pending_q && enable;
      xfer_done_s = accepted_q && i2c_finished && i2c_ready;
      wd_expire_s = (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
      raw_x_s     = buf_q[15:0];
      raw_y_s     = buf_q[31:16];
      raw_z_s     = {i2c_read_data, buf_q[39:32]};
`ifdef ACCEL_AVG_EN
      sum_x_s     = acc_x_q + sext18(raw_x_s);
      sum_y_s     = acc_y_q + sext18(raw_y_s);
      sum_z_s     = acc_z_q + sext18(raw_z_s);
`endif
   end

   // Tick generator runs only once configuration is done; a tick landing on a full pending slot is lost.
   always_comb begin
      tick_s = 1'b0;
      if (init_done_q) begin
         if (tick_cnt_q == TICK_CYCLES - 32'd1) begin
            tick_cnt_d = 32'd0;
            tick_s     = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + 32'd1;
         end
      end else begin
         tick_cnt_d = 32'd0;
      end
      if (tick_s && pending_q && !take_s) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
      if (tick_s) begin
         pending_d = 1'b1;
      end else if (take_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_q <= 32'd0;
         pending_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= PWRUP;
         pwr_cnt_q   <= 32'd0;
         wd_cnt_q    <= 32'd0;
         cfg_idx_q   <= 2'd0;
         byte_idx_q  <= 3'd0;
         accepted_q  <= 1'b0;
         buf_q       <= 40'd0;
         dev_addr_q  <= DEV_ADDRESS;
         reg_addr_q  <= 8'h00;
         wdata_q     <= 8'h00;
         r_w_q       <= 1'b1;
         start_q     <= 1'b0;
         valid_q     <= 1'b0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
         ax_q        <= 16'd0;
         ay_q        <= 16'd0;
         az_q        <= 16'd0;
`ifdef ACCEL_AVG_EN
         acc_x_q     <= 18'd0;
         acc_y_q     <= 18'd0;
         acc_z_q     <= 18'd0;
         burst_cnt_q <= 2'd0;
`endif
      end else begin
         start_q <= 1'b0;
         valid_q <= 1'b0;
         case (state_q)
            PWRUP: begin
               if (pwr_cnt_q == POWERUP_CYCLES - 32'd1) begin
                  state_q    <= CFG_ISSUE;
                  cfg_idx_q  <= 2'd0;
                  reg_addr_q <= cfg_reg(2'd0);
                  wdata_q    <= cfg_data(2'd0);
                  r_w_q      <= 1'b0;
               end else begin
                  pwr_cnt_q <= pwr_cnt_q + 32'd1;
               end
            end
            CFG_ISSUE, RD_ISSUE: begin
               if (i2c_ready) begin
                  start_q    <= 1'b1;
                  wd_cnt_q   <= 32'd0;
                  accepted_q <= 1'b0;
                  state_q    <= (state_q == CFG_ISSUE) ? CFG_WAIT : RD_WAIT;
               end
            end
            // A finished strobe only counts after the controller has dropped ready for our request.
            CFG_WAIT, RD_WAIT: begin
               if (!i2c_ready) begin
                  accepted_q <= 1'b1;
               end
               if (xfer_done_s) begin
                  if (state_q == CFG_WAIT) begin
                     if (cfg_idx_q == 2'd2) begin
                        init_done_q <= 1'b1;
                        state_q     <= IDLE;
                     end else begin
                        cfg_idx_q  <= cfg_idx_q + 2'd1;
                        reg_addr_q <= cfg_reg(cfg_idx_q + 2'd1);
                        wdata_q    <= cfg_data(cfg_idx_q + 2'd1);
                        state_q    <= CFG_ISSUE;
                     end
                  end else if (byte_idx_q == 3'd5) begin
                     state_q <= PUBLISH;
`ifdef ACCEL_AVG_EN
                     burst_cnt_q <= burst_cnt_q + 2'd1;
                     if (burst_cnt_q == 2'd3) begin
                        ax_q    <= sum_x_s[17:2];
                        ay_q    <= sum_y_s[17:2];
                        az_q    <= sum_z_s[17:2];
                        valid_q <= 1'b1;
                        acc_x_q <= 18'd0;
                        acc_y_q <= 18'd0;
                        acc_z_q <= 18'd0;
                     end else begin
                        acc_x_q <= sum_x_s;
                        acc_y_q <= sum_y_s;
                        acc_z_q <= sum_z_s;
                     end
`else
                     ax_q    <= raw_x_s;
                     ay_q    <= raw_y_s;
                     az_q    <= raw_z_s;
                     valid_q <= 1'b1;
`endif
                  end else begin
                     buf_q[{byte_idx_q, 3'b000} +: 8] <= i2c_read_data;
                     byte_idx_q <= byte_idx_q + 3'd1;
                     reg_addr_q <= 8'h32 + {5'b00000, byte_idx_q + 3'd1};
                     state_q    <= RD_ISSUE;
                  end
               end else if (wd_expire_s) begin
                  state_q <= ERROR;
                  err_q   <= 1'b1;
               end else begin
                  wd_cnt_q <= wd_cnt_q + 32'd1;
               end
            end
            IDLE: begin
               if (take_s) begin
                  byte_idx_q <= 3'd0;
                  reg_addr_q <= 8'h32;
                  r_w_q      <= 1'b1;
                  state_q    <= RD_ISSUE;
               end
            end
            PUBLISH: begin
               state_q <= IDLE;
            end
            ERROR: begin
               state_q <= ERROR;
            end
            default: begin
               state_q <= ERROR;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   assign i2c_dev_addr   = dev_addr_q;
   assign i2c_reg_addr   = reg_addr_q;
   assign i2c_r_w        = r_w_q;
   assign i2c_write_data = wdata_q;
   assign i2c_start      = start_q;
   assign accel_x        = ax_q;
   assign accel_y        = ay_q;
   assign accel_z        = az_q;
   assign accel_valid    = valid_q;
   assign init_done      = init_done_q;
   assign err            = err_q;
   assign overrun        = overrun_q;
endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Bench for accel_sample_sequencer: behavioural I2C controller, byte-log reference model, directed phases.
module tb_accel_sample_sequencer;
   localparam int unsigned CLK_HZ = 100000;
   localparam int unsigned RATE   = 100;
   localparam int unsigned PWR    = 200;
   localparam int unsigned TMO    = 3000;
`ifdef ACCEL_AVG_EN
   localparam int BPP = 4;
`else
   localparam int BPP = 1;
`endif

   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
   logic [6:0]  i2c_dev_addr;
   logic [7:0]  i2c_reg_addr, i2c_write_data;
   logic [7:0]  i2c_read_data = 8'h00;
   logic        i2c_r_w, i2c_start;
   logic        i2c_finished = 1'b0, i2c_ready = 1'b1;
   logic [15:0] accel_x, accel_y, accel_z;
   logic        accel_valid, init_done, err, overrun;

   int checks = 0, failures = 0, cyc = 0;

   accel_sample_sequencer #(
      .SYS_CLK_SPEED(CLK_HZ), .SAMPLE_RATE_HZ(RATE), .DEV_ADDRESS(7'h1D),
      .POWERUP_CYCLES(PWR), .TIMEOUT_CYCLES(TMO), .DATA_FORMAT_VAL(8'h0B)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .i2c_dev_addr(i2c_dev_addr), .i2c_reg_addr(i2c_reg_addr), .i2c_r_w(i2c_r_w),
      .i2c_write_data(i2c_write_data), .i2c_read_data(i2c_read_data), .i2c_start(i2c_start),
      .i2c_finished(i2c_finished), .i2c_ready(i2c_ready),
      .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .accel_valid(accel_valid),
      .init_done(init_done), .err(err), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural controller: accepts a start, drops ready, finishes lat cycles later.
   int   lat = 20;
   bit   hang = 1'b0, use_fixed = 1'b1, busy = 1'b0;
   int   cnt = 0;
   logic cur_rw = 1'b0;
   logic [7:0] cur_byte = 8'h00;
   logic [7:0] fixed_mem [0:5] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80};
   logic [7:0] rd_log[$];

   always @(posedge clk) begin
      i2c_finished <= 1'b0;
      if (busy) begin
         if (cnt >= lat - 1) begin
            busy <= 1'b0;
            i2c_ready <= 1'b1;
            i2c_finished <= 1'b1;
            if (cur_rw) begin
               i2c_read_data <= cur_byte;
               rd_log.push_back(cur_byte);
            end
         end else begin
            cnt <= cnt + 1;
         end
      end else if (i2c_start && !hang) begin
         busy <= 1'b1;
         i2c_ready <= 1'b0;
         cnt <= 0;
         cur_rw <= i2c_r_w;
         cur_byte <= use_fixed ? fixed_mem[i2c_reg_addr - 8'h32] : 8'($urandom);
      end
   end

   // Monitors: every start request and every publish, with expected value from the byte log.
   logic [7:0]  st_reg[$], st_data[$];
   logic        st_rw[$];
   int          st_cyc[$];
   logic [47:0] pub_obs[$], pub_exp[$];
   int          pub_cyc[$];
   int          pub_cnt = 0, dbl_start = 0;
   logic        prev_start = 1'b0;

   function automatic logic [47:0] model_expect();
      int n, b, sx, sy, sz;
      n = rd_log.size();
      if (n < 6 * BPP) return {48{1'bx}};
      sx = 0; sy = 0; sz = 0;
      for (int k = 0; k < BPP; k++) begin
         b = n - 6 * (k + 1);
         sx += int'($signed({rd_log[b+1], rd_log[b]}));
         sy += int'($signed({rd_log[b+3], rd_log[b+2]}));
         sz += int'($signed({rd_log[b+5], rd_log[b+4]}));
      end
      sx = sx >>> $clog2(BPP);
      sy = sy >>> $clog2(BPP);
      sz = sz >>> $clog2(BPP);
      return {16'(sx), 16'(sy), 16'(sz)};
   endfunction

   always @(negedge clk) begin
      if (i2c_start) begin
         st_reg.push_back(i2c_reg_addr);
         st_data.push_back(i2c_write_data);
         st_rw.push_back(i2c_r_w);
         st_cyc.push_back(cyc);
      end
      if (i2c_start && prev_start) dbl_start <= dbl_start + 1;
      prev_start <= i2c_start;
      if (accel_valid) begin
         pub_obs.push_back({accel_x, accel_y, accel_z});
         pub_exp.push_back(model_expect());
         pub_cyc.push_back(cyc);
         pub_cnt <= pub_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string p);
      check({p, "_accel_x"}, accel_x, 16'h0000);
      check({p, "_accel_y"}, accel_y, 16'h0000);
      check({p, "_accel_z"}, accel_z, 16'h0000);
      check({p, "_valid"}, accel_valid, 1'b0);
      check({p, "_start"}, i2c_start, 1'b0);
      check({p, "_init_done"}, init_done, 1'b0);
      check({p, "_err"}, err, 1'b0);
      check({p, "_overrun"}, overrun, 1'b0);
      check({p, "_dev_addr"}, i2c_dev_addr, 7'h1D);
      check({p, "_reg_addr"}, i2c_reg_addr, 8'h00);
      check({p, "_r_w"}, i2c_r_w, 1'b1);
      check({p, "_wdata"}, i2c_write_data, 8'h00);
   endtask

   task automatic check_pubs();
      while (pub_obs.size() > 0) check("pub_model", pub_obs.pop_front(), pub_exp.pop_front());
   endtask

   task automatic wait_pubs(input int n, input int budget, input string tag);
      int p0 = pub_cnt;
      for (int i = 0; i < budget && pub_cnt < p0 + n; i++) @(negedge clk);
      check(tag, pub_cnt >= p0 + n, 1'b1);
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int s0 = st_reg.size();
      for (int i = 0; i < budget && st_reg.size() < s0 + n; i++) @(negedge clk);
      check(tag, st_reg.size() >= s0 + n, 1'b1);
   endtask

   // Release reset, then expect the powerup gap and the three configuration writes.
   task automatic bring_up(input string p);
      int r0, n0;
      logic [7:0] cfg_r [0:2] = '{8'h31, 8'h2C, 8'h2D};
      logic [7:0] cfg_d [0:2] = '{8'h0B, 8'h0A, 8'h08};
      rst_n = 1'b1;
      r0 = cyc;
      n0 = st_reg.size();
      for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
      check({p, "_init_done"}, init_done, 1'b1);
      check({p, "_cfg_count"}, st_reg.size() - n0, 3);
      check({p, "_powerup_gap"}, (st_cyc[n0] - r0) >= int'(PWR), 1'b1);
      for (int k = 0; k < 3; k++) begin
         check({p, "_cfg_reg"}, st_reg[n0+k], cfg_r[k]);
         check({p, "_cfg_data"}, st_data[n0+k], cfg_d[k]);
         check({p, "_cfg_rw"}, st_rw[n0+k], 1'b0);
      end
      rd_log.delete();
   endtask

   initial begin
      int n0, n1, i32, s0, te, ts, last;
      logic [47:0] saved;

      enable = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("rst0");
      bring_up("boot");

      // Fixed byte pattern gives x=+1, y=-1, z=most negative.
      wait_pubs(1, 6000, "pub_fixed_wait");
      check("pub_fixed_x", accel_x, 16'h0001);
      check("pub_fixed_y", accel_y, 16'hFFFF);
      check("pub_fixed_z", accel_z, 16'h8000);
      n0 = st_reg.size();
      for (int k = 0; k < 6; k++) begin
         check("burst_reg_order", st_reg[n0-6+k], 8'h32 + 8'(k));
         check("burst_rw", st_rw[n0-6+k], 1'b1);
      end
      check("valid_latency", pub_cyc[pub_cyc.size()-1] - st_cyc[n0-1], lat + 2);
      check_pubs();
      use_fixed = 1'b0;

      wait_pubs(3, 16000, "pub_rand_wait");
      check_pubs();
      check("no_overrun_nominal", overrun, 1'b0);

      // Drop enable after the third byte of a burst has been requested.
      n0 = st_reg.size();
      for (int i = 0; i < 4000 && !(st_reg.size() > n0 && st_reg[st_reg.size()-1] == 8'h34); i++)
         @(negedge clk);
      enable = 1'b0;
      i32 = st_reg.size() - 3;
      s0 = st_cyc[i32];
      repeat (300) @(negedge clk);
      check("dis_burst_complete", st_reg.size() - i32, 6);
      check("dis_burst_last_reg", st_reg[st_reg.size()-1], 8'h37);
      check_pubs();
      n1 = st_reg.size();
      while (cyc < s0 + 1500) @(negedge clk);
      check("dis_no_start", st_reg.size(), n1);
      check("dis_no_overrun", overrun, 1'b0);
      enable = 1'b1;
      te = cyc;
      repeat (250) @(negedge clk);
      check("reen_one_burst", st_reg.size() - n1, 6);
      check("reen_prompt", (st_cyc[n1] - te) <= 3, 1'b1);

      // Long transactions make a burst outlast the tick period.
      lat = 300;
      wait_starts(20, 9000, "ovr_wait");
      check("ovr_sticky", overrun, 1'b1);
      last = -1;
      for (int i = st_reg.size() - 1; i > n1 + 12; i--)
         if (last < 0 && st_reg[i] == 8'h32 && st_reg[i-1] == 8'h37) last = i;
      check("ovr_found_boundary", last > 0, 1'b1);
      check("ovr_back_to_back", st_cyc[last] - st_cyc[last-1], 305);
      lat = 20;
      repeat (3000) @(negedge clk);
      check_pubs();

      // Controller stops accepting: watchdog must fire and freeze the block.
      hang = 1'b1;
      n0 = st_reg.size();
      for (int i = 0; i < 2500 && st_reg.size() <= n0; i++) @(negedge clk);
      check("tmo_start_seen", st_reg.size() > n0, 1'b1);
      ts = st_cyc[n0];
      saved = {accel_x, accel_y, accel_z};
      for (int i = 0; i < int'(TMO) + 200 && !err; i++) @(negedge clk);
      check("tmo_err", err, 1'b1);
      check("tmo_exact", cyc - ts, TMO);
      n1 = st_reg.size();
      te = pub_cnt;
      repeat (2500) @(negedge clk);
      check("tmo_no_start", st_reg.size(), n1);
      check("tmo_accel_hold", {accel_x, accel_y, accel_z}, saved);
      check("tmo_no_pub", pub_cnt, te);
      check("tmo_err_sticky", err, 1'b1);
      hang = 1'b0;

      rst_n = 1'b0;
      @(negedge clk);
      check_reset("rst_err");
      bring_up("reboot");

      // Reset while a read is outstanding.
      n0 = st_reg.size();
      wait_starts(1, 2000, "rdwait_seen");
      repeat (5) @(negedge clk);
      check("rdwait_is_read", st_rw[st_rw.size()-1], 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("rst_rd");
      n0 = st_reg.size();
      bring_up("reboot2");
      check_pubs();
      check("single_cycle_start", dbl_start, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/accel_sample_sequencer.md
Name: accel_sample_sequencer

Overview:
- Command sequencer directly upstream of the I2C controller; sole owner of its request interface.
- After reset: waits out sensor power-up, issues three register writes to configure the accelerometer, then reads the six data registers 0x32..0x37 at a fixed sample rate.
- Assembles X/Y/Z as signed 16-bit words and presents them atomically, with a valid pulse, to the 7-seg display path.

Parameters:
- SYS_CLK_SPEED, 50000000, system clock in Hz.
- SAMPLE_RATE_HZ, 100, sample tick rate; tick period TICK_CYCLES = SYS_CLK_SPEED/SAMPLE_RATE_HZ.
- DEV_ADDRESS, 7'h1D, I2C device address driven to the controller.
- POWERUP_CYCLES, 100000, delay after reset before the first transaction.
- TIMEOUT_CYCLES, 2000000, per-transaction watchdog limit.
- DATA_FORMAT_VAL, 8'h0B, value written to register 0x31.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- enable  in  1  1 = sampling allowed
- i2c_dev_addr  out  7  to controller DEV_ADDR
- i2c_reg_addr  out  8  to controller REG_ADDR
- i2c_r_w  out  1  1 = read, 0 = write
- i2c_write_data  out  8  to controller WRITE_DATA
- i2c_read_data  in  8  from controller READ_DATA
- i2c_start  out  1  to controller start_i2c_comms
- i2c_finished  in  1  from controller i2c_comms_finished
- i2c_ready  in  1  from controller ready
- accel_x, accel_y, accel_z  out  16 each  signed samples
- accel_valid  out  1  one-cycle pulse on update
- init_done  out  1  configuration complete
- err  out  1  sticky watchdog error
- overrun  out  1  sticky, a tick was dropped

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values:
  - Outputs: accel_* = 0, accel_valid/i2c_start/init_done/err/overrun = 0.
  - i2c_dev_addr = DEV_ADDRESS, i2c_reg_addr = 0, i2c_r_w = 1, i2c_write_data = 0.
  - State PWRUP; all counters cleared.
- rst_n low mid-transaction: same reset values; the controller is not otherwise informed.
- States: PWRUP, CFG_ISSUE, CFG_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH, ERROR.
- PWRUP: count POWERUP_CYCLES, then go to CFG_ISSUE with cfg index 0.
- Config list, in order (reg, data):
  - (0x31, DATA_FORMAT_VAL)
  - (0x2C, 0x0A)
  - (0x2D, 0x08)
  - All writes use i2c_r_w = 0.
- ISSUE states:
  - Drive address and data.
  - When i2c_ready = 1, assert i2c_start for exactly one cycle, clear the watchdog, and go to the WAIT state.
- WAIT states:
  - Outputs held stable.
  - Set the accepted flag on the first cycle i2c_ready = 0.
  - Done when accepted = 1, i2c_finished = 1 and i2c_ready = 1 in the same cycle.
  - i2c_finished high before acceptance is stale and ignored.
- Config completion: after the third write, init_done = 1 (stays 1 until reset) and go to IDLE.
- Sample tick:
  - Free-running TICK_CYCLES counter, started when init_done rises.
  - One-deep pending flag.
  - Tick while pending is already set: set overrun; the extra tick is dropped.
- IDLE: if pending = 1 and enable = 1, clear pending, set byte index 0, go to RD_ISSUE.
- enable = 0: an in-progress six-byte burst still completes; ticks are still counted and pended.
- Read burst:
  - Each byte is a single-byte read transaction: i2c_r_w = 1, i2c_reg_addr = 0x32 + index.
  - On completion, latch i2c_read_data into buffer[index].
  - index < 5: increment and return to RD_ISSUE. index = 5: go to PUBLISH.
- PUBLISH (one cycle):
  - accel_x = {buf1, buf0}, accel_y = {buf3, buf2}, accel_z = {buf5, buf4}.
  - All three update in the same cycle, with accel_valid = 1 for that cycle only.
  - Outputs are never partially updated; they hold between publishes.
  - Return to IDLE.
- Watchdog:
  - Counts in any WAIT state.
  - Reaching TIMEOUT_CYCLES: go to ERROR, set err = 1.
  - ERROR is terminal until reset; i2c_start stays 0 there and accel_* hold their last values.
- Latency: accel_valid asserts the cycle after completion of the sixth read.

Optional Feature:
- Macro: ACCEL_AVG_EN.
- Defined:
  - Accumulate 4 consecutive bursts per axis in 18-bit signed accumulators.
  - On every 4th burst, publish accumulator >>> 2 (arithmetic shift), pulse accel_valid, and clear the accumulators.
  - The first valid pulse comes after 4 bursts.
  - Reset clears the accumulators and the burst count.
- Undefined: every burst publishes raw values directly; no accumulators exist.

Test Plan:
- Reset release with a behavioural controller model (ready = 1, finishes 500 cycles after start): three i2c_start pulses with (reg, data, r_w) = (0x31, 0x0B, 0), (0x2C, 0x0A, 0), (0x2D, 0x08, 0), then init_done = 1; no start during the first 100000 cycles.
- Model returns 0x01, 0x00, 0xFF, 0xFF, 0x00, 0x80 for 0x32..0x37 → one accel_valid pulse with x = 0x0001, y = 0xFFFF (−1), z = 0x8000; reg addresses seen in order 0x32..0x37.
- Model holds ready = 1 and never finishes → err = 1 exactly TIMEOUT_CYCLES after the start pulse; no further i2c_start; accel_* unchanged.
- SAMPLE_RATE_HZ set so the tick period is shorter than one burst → overrun = 1 and back-to-back bursts with no gap beyond one IDLE cycle.
- enable = 0 asserted mid-burst → the current burst completes and publishes; no new start until enable = 1, then exactly one burst starts for the pended tick.
- rst_n low during RD_WAIT → next cycle all outputs at reset values, i2c_start = 0; sequence restarts from PWRUP.
